// File: rtl/capture_ctrl_pkg.sv
// Shared scope constants: sample/bank geometry, waveform window placement,
// capture FSM encoding and the window test used by the display read path.
package capture_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int X_OFF  = 10;
  localparam int W      = 50;

  localparam logic [3:0] COL_BG   = 4'h0;
  localparam logic [3:0] COL_GRID = 4'h8;
  localparam logic [3:0] COL_WAVE = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic in_window(input logic [9:0] x);
    return (x >= 10'(X_OFF)) && (x < 10'(X_OFF + W));
  endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample RAM bus: capture-side write port and renderer-side read address.
interface capture_ctrl_if;
  import capture_ctrl_pkg::*;

  logic              wr_en;
  logic [ADDR_W:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   rd_addr;
  logic              rd_valid;

  modport master (output wr_en, output wr_addr, output wr_data,
                  output rd_addr, output rd_valid);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data,
                  input  rd_addr, input  rd_valid);

endinterface

// File: rtl/capture_ctrl_trig_detect.sv
// Rising-edge trigger: fires when the stream crosses trig_level upwards
// between two consecutive valid samples.
module capture_ctrl_trig_detect
  import capture_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] trig_level,
  output logic              trig_hit
);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    if (sample_valid) begin
      prev_d      = sample;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign trig_hit = sample_valid && have_prev_q &&
                    (prev_q < trig_level) && (sample >= trig_level);

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer for the scope: triggers, fills the back bank of the
// sample RAM and swaps banks at frame start; also maps raster x to a read address.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int AUTO_N = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x_px,
  input  logic [9:0]        y_px,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic              run,
  input  logic [DATA_W-1:0] trig_level,
  capture_ctrl_if.master    bus,
  output logic              disp_bank,
  output logic              swapped,
  output logic              auto_trig,
  output logic [1:0]        state
);

  localparam int CW = $clog2(AUTO_N + 1);
  localparam logic [CW-1:0]     AUTO_LAST = CW'(AUTO_N - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(W - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [CW-1:0]     auto_cnt_q, auto_cnt_d;
  logic              auto_trig_q, auto_trig_d;
  logic              disp_bank_q, disp_bank_d;
  logic              swapped_q, swapped_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              fs_prev_q;
  logic              frame_start, fs_rise, trig_hit, auto_hit;

  capture_ctrl_trig_detect u_trig (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .trig_level   (trig_level),
    .trig_hit     (trig_hit)
  );

  assign frame_start = (x_px == 10'd0) && (y_px == 10'd0);
  assign fs_rise     = frame_start && !fs_prev_q;
  assign auto_hit    = sample_valid && (auto_cnt_q == AUTO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Abort (run low) takes priority over any trigger or fill progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (run) state_d = WAIT;
      WAIT: begin
        if (!run)                                 state_d = IDLE;
        else if (sample_valid && (trig_hit || auto_hit)) state_d = FILL;
      end
      FILL: begin
        if (!run)                                   state_d = IDLE;
        else if (sample_valid && index_q == IDX_LAST) state_d = DONE;
      end
      DONE: if (fs_rise) state_d = run ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    index_d     = index_q;
    auto_cnt_d  = auto_cnt_q;
    auto_trig_d = auto_trig_q;
    disp_bank_d = disp_bank_q;
    swapped_d   = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    case (state_q)
      IDLE: if (run) begin
        index_d    = '0;
        auto_cnt_d = '0;
      end
      WAIT: begin
        if (!run) begin
          index_d = '0;
        end else if (sample_valid) begin
          if (trig_hit || auto_hit) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = {~disp_bank_q, {ADDR_W{1'b0}}};
            wr_data_d   = sample;
            index_d     = ADDR_W'(1);
            auto_trig_d = !trig_hit;
          end else begin
            auto_cnt_d = auto_cnt_q + 1'b1;
          end
        end
      end
      FILL: begin
        if (!run) begin
          index_d = '0;
        end else if (sample_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {~disp_bank_q, index_q};
          wr_data_d = sample;
          index_d   = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
        end
      end
      DONE: if (fs_rise) begin
        disp_bank_d = ~disp_bank_q;
        swapped_d   = 1'b1;
        index_d     = '0;
        auto_cnt_d  = '0;
      end
      default: ;
    endcase
  end

  // Read path uses the pre-swap bank; the swap lands one cycle later.
  always_comb begin
    rd_valid_d = in_window(x_px);
    rd_addr_d  = rd_addr_q;
    if (rd_valid_d) rd_addr_d = {disp_bank_q, ADDR_W'(x_px - 10'(X_OFF))};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q     <= '0;
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
      disp_bank_q <= 1'b0;
      swapped_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      rd_valid_q  <= 1'b0;
      fs_prev_q   <= 1'b0;
    end else begin
      index_q     <= index_d;
      auto_cnt_q  <= auto_cnt_d;
      auto_trig_q <= auto_trig_d;
      disp_bank_q <= disp_bank_d;
      swapped_q   <= swapped_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      rd_valid_q  <= rd_valid_d;
      fs_prev_q   <= frame_start;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign disp_bank    = disp_bank_q;
  assign swapped      = swapped_q;
  assign auto_trig    = auto_trig_q;
  assign state        = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: trigger, fill, swap, auto-trigger, abort,
// read mapping and asynchronous reset in the middle of a capture.
module tb_capture_ctrl;
  import capture_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] x_px = 10'd200;
  logic [9:0] y_px = 10'd100;
  logic [7:0] sample = 8'd0;
  logic       sample_valid = 1'b0;
  logic       run = 1'b0;
  logic [7:0] trig_level = 8'd128;
  wire        disp_bank, swapped, auto_trig;
  wire [1:0]  state;
  int         checks = 0;
  int         errors = 0;

  capture_ctrl_if bus_if ();

  capture_ctrl #(.AUTO_N(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .x_px         (x_px),
    .y_px         (y_px),
    .sample       (sample),
    .sample_valid (sample_valid),
    .run          (run),
    .trig_level   (trig_level),
    .bus          (bus_if),
    .disp_bank    (disp_bank),
    .swapped      (swapped),
    .auto_trig    (auto_trig),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s);
    sample       = s;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    int pulses;

    step();
    step();
    check("rst_state", state, 0);
    check("rst_bank", disp_bank, 0);
    check("rst_wr_en", bus_if.wr_en, 0);
    check("rst_rd_valid", bus_if.rd_valid, 0);
    check("rst_swapped", swapped, 0);
    check("rst_auto", auto_trig, 0);
    reset = 1'b1;
    step();

    // Ramp trigger at 128: 120 and 125 stay below, 130 crosses.
    run = 1'b1;
    trig_level = 8'd128;
    step();
    check("idle_to_wait", state, 1);
    send(8'd120);
    check("wait_120", state, 1);
    check("wait_no_wr", bus_if.wr_en, 0);
    send(8'd125);
    check("wait_125", state, 1);
    s = 8'd130;
    send(s);
    check("trig_state", state, 2);
    check("trig_wr_en", bus_if.wr_en, 1);
    check("trig_addr", bus_if.wr_addr, 64);
    check("trig_data", bus_if.wr_data, 130);
    check("trig_auto", auto_trig, 0);
    for (int i = 1; i < 50; i++) begin
      s = s + 8'd5;
      send(s);
      check("ramp_addr", bus_if.wr_addr, 64 + i);
      check("ramp_data", bus_if.wr_data, s);
    end
    check("fill_done", state, 3);
    step();
    check("wr_one_cycle", bus_if.wr_en, 0);
    check("done_hold", state, 3);
    send(8'd40);
    check("done_no_wr", bus_if.wr_en, 0);
    check("done_no_swap", disp_bank, 0);

    // Frame start held for 3 cycles: exactly one swap.
    x_px = 10'd0;
    y_px = 10'd0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin
        check("swap_bank", disp_bank, 1);
        check("swap_state", state, 1);
      end
      pulses += int'(swapped);
    end
    check("swap_pulses", pulses, 1);
    x_px = 10'd200;
    y_px = 10'd100;

    // Auto-trigger: flat signal below threshold, fires on the 8th sample.
    trig_level = 8'd100;
    for (int i = 0; i < 7; i++) send(8'd50);
    check("auto_wait", state, 1);
    check("auto_no_wr", bus_if.wr_en, 0);
    send(8'd50);
    check("auto_state", state, 2);
    check("auto_flag", auto_trig, 1);
    check("auto_wr_en", bus_if.wr_en, 1);
    check("auto_addr", bus_if.wr_addr, 0);
    check("auto_data", bus_if.wr_data, 50);
    for (int i = 1; i <= 10; i++) send(8'd50);
    check("fill10_addr", bus_if.wr_addr, 10);
    check("fill10_state", state, 2);

    // Abort mid-fill.
    run = 1'b0;
    step();
    check("abort_state", state, 0);
    check("abort_swapped", swapped, 0);
    check("abort_bank", disp_bank, 1);
    step();
    check("abort_swapped2", swapped, 0);
    check("abort_no_wr", bus_if.wr_en, 0);

    // Read mapping with front bank 1.
    x_px = 10'd9;
    step();
    check("rd_x9_valid", bus_if.rd_valid, 0);
    x_px = 10'd10;
    step();
    check("rd_x10_valid", bus_if.rd_valid, 1);
    check("rd_x10_addr", bus_if.rd_addr, 64);
    x_px = 10'd35;
    step();
    check("rd_x35_addr", bus_if.rd_addr, 89);
    x_px = 10'd59;
    step();
    check("rd_x59_valid", bus_if.rd_valid, 1);
    check("rd_x59_addr", bus_if.rd_addr, 113);
    x_px = 10'd60;
    step();
    check("rd_x60_valid", bus_if.rd_valid, 0);
    check("rd_x60_hold", bus_if.rd_addr, 113);

    // New capture into bank 0, then asynchronous reset after 20 writes.
    x_px = 10'd20;
    run = 1'b1;
    trig_level = 8'd128;
    step();
    send(8'd120);
    send(8'd130);
    check("cap2_auto_clr", auto_trig, 0);
    check("cap2_addr0", bus_if.wr_addr, 0);
    for (int i = 1; i < 20; i++) send(8'd140);
    check("cap2_addr19", bus_if.wr_addr, 19);
    check("cap2_wr_en", bus_if.wr_en, 1);
    check("cap2_rd_valid", bus_if.rd_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_bank", disp_bank, 0);
    check("arst_wr_en", bus_if.wr_en, 0);
    check("arst_wr_addr", bus_if.wr_addr, 0);
    check("arst_wr_data", bus_if.wr_data, 0);
    check("arst_rd_addr", bus_if.rd_addr, 0);
    check("arst_rd_valid", bus_if.rd_valid, 0);
    check("arst_swapped", swapped, 0);
    check("arst_auto", auto_trig, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sequences sample capture for the scope display and arbitrates a double-banked sample RAM between the capture side and the `waveform` renderer.
- Capture side: trigger detection, auto-trigger timeout, sequential write of W samples into the back bank.
- Display side: maps the raster position (`x_px`, `y_px`) to a read address in the front bank.
- Bank swaps occur only at frame start, so the renderer never shows a torn capture.

Parameters:
X_OFF, 10, left pixel column of the waveform window
W, 50, samples per capture (= window width in pixels); W <= 2**ADDR_W
ADDR_W, 6, per-bank address width
DATA_W, 8, sample width
AUTO_N, 1000, valid samples in WAIT without a trigger before auto-trigger fires

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
x_px  in  10  current raster column
y_px  in  10  current raster row
sample  in  DATA_W  ADC sample
sample_valid  in  1  one-cycle strobe qualifying sample
run  in  1  level; 1 = keep capturing, 0 = stop/abort
trig_level  in  DATA_W  rising-edge trigger threshold (unsigned)
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W+1  {bank, index}
wr_data  out  DATA_W  RAM write data
rd_addr  out  ADDR_W+1  {front bank, index} for renderer
rd_valid  out  1  rd_addr lies inside the window
disp_bank  out  1  current front bank
swapped  out  1  one-cycle pulse on bank swap
auto_trig  out  1  last capture was auto-triggered (sticky until next trigger)
state  out  2  FSM state, for debug

Behaviour:
- Reset (`reset` = 0, asynchronous): state = IDLE.
  - All outputs 0; disp_bank = 0.
  - prev_sample = 0, have_prev = 0, index = 0, auto_cnt = 0.
- State encoding: IDLE = 0, WAIT = 1, FILL = 2, DONE = 3.
- prev_sample tracking (every state): each `sample_valid` cycle, prev_sample <= sample and have_prev <= 1.
- Trigger condition: `sample_valid` && have_prev && prev_sample < trig_level && sample >= trig_level.
- IDLE -> WAIT when `run` = 1. auto_cnt and index are cleared on entry to WAIT.
- WAIT:
  - Each `sample_valid` without a trigger increments auto_cnt.
  - Trigger -> FILL, auto_trig <= 0.
  - If instead auto_cnt == AUTO_N-1 on a `sample_valid` cycle -> FILL, auto_trig <= 1.
  - In both cases the qualifying sample is written as index 0.
- FILL: each `sample_valid` writes the sample at index, then index++. After the write of index W-1 -> DONE.
- Write timing: registered, one cycle after `sample_valid`.
  - wr_en = 1 for exactly one cycle.
  - wr_addr = {~disp_bank, index}; wr_data = the sample.
  - The write never targets the front bank.
- DONE: waits for frame start (`x_px` == 0 && `y_px` == 0, first cycle of that condition only). Then:
  - disp_bank toggles and `swapped` pulses for 1 cycle.
  - Next state is WAIT if `run` = 1, else IDLE.
- `run` = 0 in WAIT or FILL: next cycle -> IDLE.
  - Partial capture is discarded: no swap, disp_bank unchanged.
  - index cleared; any pending registered write still completes.
- `run` = 0 in DONE: the swap still happens at the next frame start, then -> IDLE.
- Display read, 1-cycle latency:
  - If X_OFF <= `x_px` < X_OFF+W: rd_addr <= {disp_bank, `x_px`-X_OFF} (truncated to ADDR_W), rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_addr holds its previous value.
  - The subtraction is done at 10 bits; the comparison uses X_OFF+W as a constant.
- Simultaneous events:
  - Frame start in DONE while `sample_valid`: swap wins; the sample only updates prev_sample.
  - Swap and a read in the same cycle: rd_addr uses the pre-swap disp_bank (registered next cycle with the new bank).
- Frame start is evaluated only in DONE; repeated cycles with `x_px` = `y_px` = 0 produce a single swap (edge-detect on the frame-start condition).

Decomposition:
- Shared package (`scope_pkg`): state encoding constants (IDLE/WAIT/FILL/DONE), DATA_W, ADDR_W, and the screen constants already used by `waveform` (X_OFF, W, colour codes).
- One natural sub-module, `trig_detect`: prev_sample/have_prev registers and the rising-edge comparison, output `trig_hit`.
- FSM, write-address logic and read mapping stay in `capture_ctrl`.

Test Plan:
- Reset mid-FILL: assert `reset` low after 20 writes -> all outputs 0, state = IDLE and disp_bank = 0 immediately, without waiting for a clock edge.
- Ramp trigger: `run` = 1, trig_level = 128, samples 120, 125, 130, 135, … -> FILL entered on sample 130; wr_data at wr_addr {1, 0} = 130; 50 writes to addresses {1, 0..49}; state = DONE.
- Frame swap: in DONE, drive `x_px` = `y_px` = 0 for 3 cycles -> `swapped` pulses once, disp_bank = 1, state = WAIT; the next capture writes bank 0.
- Auto-trigger: AUTO_N = 8, constant sample = 50, trig_level = 100 -> FILL after the 8th valid sample, auto_trig = 1, that sample written at index 0.
- Abort: drop `run` after 10 FILL writes -> IDLE next cycle, no `swapped` pulse, disp_bank unchanged.
- Read mapping:
  - `x_px` = 9 -> rd_valid = 0.
  - `x_px` = 10 -> next cycle rd_addr = {disp_bank, 0}, rd_valid = 1.
  - `x_px` = 59 -> rd_addr index 49.
  - `x_px` = 60 -> rd_valid = 0.
